trng_word_reader: RTL and testbench

//  Consumer end of the TRNG word stream: captures each 64-bit word presented with a one-cycle
//  in_valid strobe (no backpressure on that side) into a small FIFO. Drains each word as two
//  32-bit beats over a valid/ready stream toward the Zynq PS / AXI-Stream bridge.

---
 rtl/trng_pkg.sv | 23 ++
 rtl/trng_word_fifo.sv | 54 +++++
 rtl/trng_word_reader.sv | 92 +++++++++
 tb/tb_trng_word_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared widths and helpers for the TRNG word path (bit collector, word reader, PS bridge).
package trng_pkg;

  localparam int WORD_W = 64;
  localparam int BEAT_W = 32;

  typedef enum logic {
    HALF_LOW  = 1'b0,
    HALF_HIGH = 1'b1
  } half_e;

  // Select the low or high 32-bit beat of a 64-bit word.
  function automatic logic [BEAT_W-1:0] beat_sel(input logic [WORD_W-1:0] word, input logic hi);
    logic [BEAT_W-1:0] beat;
    if (hi) begin
      beat = word[WORD_W-1:BEAT_W];
    end else begin
      beat = word[BEAT_W-1:0];
    end
    return beat;
  endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous word FIFO with combinational head read; the caller guarantees push/pop legality.
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_data,
  input  logic                     pop,
  output logic [WORD_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    level_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + (PTR_W+1)'(1);
        2'b01:   level_r <= level_r - (PTR_W+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array write; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;

endmodule

// File: rtl/trng_word_reader.sv
// TRNG word reader: buffers 64-bit words, drains them as low/high 32-bit beats, counts drops.
module trng_word_reader
  import trng_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic [BEAT_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  input  logic                   clr_stat
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  half_e               half_r;
  logic                overflow_r;
  logic [CNT_W-1:0]    drop_count_r;
  logic [WORD_W-1:0]   head_s;
  logic [LVL_W-1:0]    level_s;
  logic                valid_s;
  logic                accept_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;

  trng_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (in_data),
    .pop       (pop_s),
    .head      (head_s),
    .level     (level_s)
  );

  // A full FIFO still takes a word when the high beat leaves in the same cycle.
  always_comb begin
    valid_s  = (level_s != {LVL_W{1'b0}});
    accept_s = valid_s & m_ready;
    pop_s    = accept_s & (half_r == HALF_HIGH);
    push_s   = in_valid & ((level_s < LVL_W'(DEPTH)) | pop_s);
    drop_s   = in_valid & ~push_s;
  end

  // Beat select FSM: low beat first, flips on every accepted beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      half_r <= HALF_LOW;
    end else if (accept_s) begin
      case (half_r)
        HALF_LOW:  half_r <= HALF_HIGH;
        HALF_HIGH: half_r <= HALF_LOW;
        default:   half_r <= HALF_LOW;
      endcase
    end
  end

  // Drop statistics; a drop coinciding with clr_stat leaves a count of one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_r   <= 1'b0;
      drop_count_r <= {CNT_W{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (clr_stat) begin
        drop_count_r <= CNT_W'(1);
      end else if (drop_count_r != {CNT_W{1'b1}}) begin
        drop_count_r <= drop_count_r + CNT_W'(1);
      end
    end else if (clr_stat) begin
      overflow_r   <= 1'b0;
      drop_count_r <= {CNT_W{1'b0}};
    end
  end

  assign m_valid    = valid_s;
  assign m_data     = beat_sel(head_s, half_r == HALF_HIGH);
  assign m_last     = valid_s & (half_r == HALF_HIGH);
  assign level      = level_s;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_trng_word_reader.sv
// Self-checking bench for trng_word_reader: directed vector table, corner sequences, random run vs queue model.
module tb_trng_word_reader;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] in_data = 64'h0;
  logic        in_valid = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [2:0]  level;
  logic        overflow;
  logic [CNT_W-1:0] drop_count;
  logic        clr_stat = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  trng_word_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .level(level), .overflow(overflow), .drop_count(drop_count), .clr_stat(clr_stat)
  );

  always #5 clk = ~clk;

  // Reference model: queue of stored words plus beat phase and statistics.
  logic [63:0] mq[$];
  bit          m_half;
  bit          m_ovf;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit iv, input logic [63:0] d, input bit rdy, input bit clr);
    bit acc, pop, push;
    if (!r) begin
      mq.delete();
      m_half = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      acc  = (mq.size() > 0) && rdy;
      pop  = acc && m_half;
      push = iv && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
      if (acc) m_half = !m_half;
      if (iv && !push) begin
        m_ovf = 1;
        m_cnt = clr ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
      end else if (clr) begin
        m_ovf = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [63:0] hw;
    chk("model m_valid", m_valid, (mq.size() != 0));
    chk("model level", level, mq.size());
    chk("model overflow", overflow, m_ovf);
    chk("model drop_count", drop_count, m_cnt);
    if (mq.size() != 0) begin
      hw = mq[0];
      chk("model m_data", m_data, m_half ? hw[63:32] : hw[31:0]);
      chk("model m_last", m_last, m_half);
    end else begin
      chk("model m_last idle", m_last, 1'b0);
    end
  endtask

  // One clock: drive at negedge, advance the model, compare just after the edge.
  task automatic cyc(input bit r, input bit iv, input logic [63:0] d, input bit rdy, input bit clr);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; m_ready = rdy; clr_stat = clr;
    model_step(r, iv, d, rdy, clr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r; bit iv; logic [63:0] d; bit rdy; bit clr;
    bit e_valid; logic [31:0] e_data; bit e_last; int e_level; bit e_ovf; int e_cnt;
  } vec_t;

  vec_t tbl[13];
  logic [31:0] beats[8];
  logic [63:0] w;

  initial begin
    // Single word, then fill/drop/clr_stat, then full+pop+push in the same cycle.
    tbl[0]  = '{0, 0, 64'h0,                   0, 0, 0, 32'h0,         0, 0, 0, 0};
    tbl[1]  = '{1, 1, 64'hDEAD_BEEF_0123_4567, 1, 0, 1, 32'h0123_4567, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 64'h0,                   1, 0, 1, 32'hDEAD_BEEF, 1, 1, 0, 0};
    tbl[3]  = '{1, 0, 64'h0,                   1, 0, 0, 32'h0,         0, 0, 0, 0};
    tbl[4]  = '{1, 1, 64'h0000_0001_1000_0000, 0, 0, 1, 32'h1000_0000, 0, 1, 0, 0};
    tbl[5]  = '{1, 1, 64'h0000_0002_2000_0000, 0, 0, 1, 32'h1000_0000, 0, 2, 0, 0};
    tbl[6]  = '{1, 1, 64'h0000_0003_3000_0000, 0, 0, 1, 32'h1000_0000, 0, 3, 0, 0};
    tbl[7]  = '{1, 1, 64'h0000_0004_4000_0000, 0, 0, 1, 32'h1000_0000, 0, 4, 0, 0};
    tbl[8]  = '{1, 1, 64'h0000_0005_5000_0000, 0, 1, 1, 32'h1000_0000, 0, 4, 1, 1};
    tbl[9]  = '{1, 0, 64'h0,                   0, 1, 1, 32'h1000_0000, 0, 4, 0, 0};
    tbl[10] = '{1, 1, 64'h0000_0006_6000_0000, 0, 0, 1, 32'h1000_0000, 0, 4, 1, 1};
    tbl[11] = '{1, 0, 64'h0,                   1, 0, 1, 32'h0000_0001, 1, 4, 1, 1};
    tbl[12] = '{1, 1, 64'h0000_0007_7000_0000, 1, 0, 1, 32'h2000_0000, 0, 4, 1, 1};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl[%0d] m_valid", i), m_valid, tbl[i].e_valid);
      chk($sformatf("tbl[%0d] level", i), level, tbl[i].e_level);
      chk($sformatf("tbl[%0d] m_last", i), m_last, tbl[i].e_last);
      chk($sformatf("tbl[%0d] overflow", i), overflow, tbl[i].e_ovf);
      chk($sformatf("tbl[%0d] drop_count", i), drop_count, tbl[i].e_cnt);
      if (tbl[i].e_valid) chk($sformatf("tbl[%0d] m_data", i), m_data, tbl[i].e_data);
    end

    // Backpressure: low beat held stable for 10 cycles, then both beats in order.
    cyc(0, 0, 64'h0, 0, 0);
    cyc(1, 1, 64'hCAFE_F00D_8765_4321, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 64'h0, 0, 0);
      chk("bp hold m_valid", m_valid, 1'b1);
      chk("bp hold m_data", m_data, 32'h8765_4321);
    end
    cyc(1, 0, 64'h0, 1, 0);
    chk("bp high beat", m_data, 32'hCAFE_F00D);
    chk("bp high last", m_last, 1'b1);
    cyc(1, 0, 64'h0, 1, 0);
    chk("bp drained", m_valid, 1'b0);

    // Overflow: 6 strobes into DEPTH=4, then exactly the first four words drain.
    cyc(0, 0, 64'h0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      w = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
      cyc(1, 1, w, 0, 0);
    end
    chk("ovf level", level, 3'd4);
    chk("ovf flag", overflow, 1'b1);
    chk("ovf count", drop_count, 4'd2);
    for (int k = 0; k < 8; k++) begin
      beats[k] = m_data;
      cyc(1, 0, 64'h0, 1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      chk("ovf drain low", beats[2*k], 32'hB000_0000 + 32'(k));
      chk("ovf drain high", beats[2*k+1], 32'hA000_0000 + 32'(k));
    end
    chk("ovf drain empty", m_valid, 1'b0);

    // Drop counter saturates at all-ones.
    cyc(0, 0, 64'h0, 0, 0);
    for (int i = 0; i < 24; i++) cyc(1, 1, 64'(i), 0, 0);
    chk("sat count", drop_count, 4'hF);

    // Reset mid-drain discards the stored words and the pending high beat.
    cyc(0, 0, 64'h0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, {32'hC0DE_0000 + 32'(i), 32'h5EED_0000 + 32'(i)}, 0, 0);
    cyc(1, 0, 64'h0, 1, 0);
    chk("mid level", level, 3'd3);
    chk("mid last", m_last, 1'b1);
    cyc(0, 0, 64'h0, 0, 0);
    chk("mid rst valid", m_valid, 1'b0);
    chk("mid rst level", level, 3'd0);
    cyc(1, 1, 64'h1234_5678_9ABC_DEF0, 0, 0);
    chk("post rst low beat", m_data, 32'h9ABC_DEF0);
    chk("post rst last", m_last, 1'b0);

    // Random traffic with varying rates against the queue model.
    for (int seg = 0; seg < 6; seg++) begin
      int iv_pct;
      int rdy_pct;
      iv_pct  = 20 + seg * 15;
      rdy_pct = 90 - seg * 12;
      for (int i = 0; i < 400; i++) begin
        cyc(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 99) < iv_pct),
            {$urandom, $urandom},
            ($urandom_range(0, 99) < rdy_pct),
            ($urandom_range(0, 39) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
